// File: rtl/normalize_left_48.sv
// normalize_left_48: 3-stage elastic leading-zero count and left-shift normalizer.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_mant/in_exp upstream handshake;
// out_valid/out_ready downstream handshake; out_mant normalized mantissa, out_exp adjusted
// exponent, out_shift applied shift, out_zero zero mantissa, out_uf exponent underflow.
module normalize_left_48 #(
  parameter int W  = 48,
  parameter int SW = 6,
  parameter int EW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_mant,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_mant,
  output logic [EW-1:0] out_exp,
  output logic [SW-1:0] out_shift,
  output logic          out_zero,
  output logic          out_uf
);
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [W-1:0] m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;
  logic [EW-1:0] e1_q, e1_d, e2_q, e2_d, e3_q, e3_d;
  logic [SW-1:0] lz1_q, lz1_d, lz2_q, lz2_d, lz3_q, lz3_d;
  logic z3_q, z3_d, uf3_q, uf3_d;
  logic adv1, adv2, adv3, ld1, ld2, ld3, zero, uf;
  logic [SW-1:0] lz;
  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    lz = SW'(W);
    for (int i = 0; i < W; i++) if (in_mant[i]) lz = SW'(W - 1 - i);
  end
  always_comb begin
    adv3  = !v3_q || out_ready;
    adv2  = !v2_q || adv3;
    adv1  = !v1_q || adv2;
    ld1   = adv1 && in_valid;
    ld2   = adv2 && v1_q;
    ld3   = adv3 && v2_q;
    zero  = lz2_q == SW'(W);
    uf    = !zero && ({{EW{1'b0}}, lz2_q} > {{SW{1'b0}}, e2_q});
    v1_d  = adv1 ? in_valid : v1_q;
    v2_d  = adv2 ? v1_q : v2_q;
    v3_d  = adv3 ? v2_q : v3_q;
    m1_d  = ld1 ? in_mant : m1_q;
    e1_d  = ld1 ? in_exp : e1_q;
    lz1_d = ld1 ? lz : lz1_q;
    m2_d  = ld2 ? m1_q << {lz1_q[SW-1:3], 3'b000} : m2_q;
    e2_d  = ld2 ? e1_q : e2_q;
    lz2_d = ld2 ? lz1_q : lz2_q;
    m3_d  = ld3 ? m2_q << lz2_q[2:0] : m3_q;
    e3_d  = ld3 ? ((zero || uf) ? '0 : e2_q - EW'(lz2_q)) : e3_q;
    lz3_d = ld3 ? lz2_q : lz3_q;
    z3_d  = ld3 ? zero : z3_q;
    uf3_d = ld3 ? uf : uf3_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      m1_q <= '0; m2_q <= '0; m3_q <= '0;
      e1_q <= '0; e2_q <= '0; e3_q <= '0;
      lz1_q <= '0; lz2_q <= '0; lz3_q <= '0;
      z3_q <= 1'b0; uf3_q <= 1'b0;
    end else begin
      v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
      m1_q <= m1_d; m2_q <= m2_d; m3_q <= m3_d;
      e1_q <= e1_d; e2_q <= e2_d; e3_q <= e3_d;
      lz1_q <= lz1_d; lz2_q <= lz2_d; lz3_q <= lz3_d;
      z3_q <= z3_d; uf3_q <= uf3_d;
    end
  end
  assign in_ready  = adv1;
  assign out_valid = v3_q;
  assign out_mant  = m3_q;
  assign out_exp   = e3_q;
  assign out_shift = lz3_q;
  assign out_zero  = z3_q;
  assign out_uf    = uf3_q;
endmodule

// File: doc/normalize_left_48.md
Name: normalize_left_48

Overview:
Pipelined leading-zero-count and left-shift normalizer. It is the inverse of the alignment right shifters in the FP datapath: it takes a post-add/post-multiply mantissa and shifts it left until its MSB is 1. It adjusts the exponent by the shift amount. It sits between the mantissa adder/multiplier and the rounder, with valid/ready handshakes on both sides.

Parameters:
W, 48, mantissa width; legal range 16..64
SW, 6, shift-count width; must satisfy 2^SW > W
EW, 10, exponent width (unsigned, biased)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream data valid
in_ready  output  1  block can accept in_mant/in_exp this cycle
in_mant  input  W  unnormalized mantissa
in_exp  input  EW  biased exponent associated with in_mant
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_mant  output  W  normalized mantissa (MSB=1 unless zero)
out_exp  output  EW  adjusted exponent
out_shift  output  SW  left-shift amount applied (leading-zero count)
out_zero  output  1  in_mant was all zeros
out_uf  output  1  exponent underflow: shift amount > in_exp

Behaviour:
- Transfer rule: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Pipeline has 3 register stages, each with its own valid bit:
  - S1: captures in_mant and in_exp, and computes lz = leading-zero count of in_mant (0..W). lz = W for zero input.
  - S2: left-shifts by the lz bits SW-1..3 (32/16/8 for the defaults) and zero-fills on the right.
  - S3: left-shifts by lz bits 2..0 (4/2/1) and computes the exponent.
- Latency: with no stall, out_valid rises exactly 3 cycles after the input transfer cycle. Throughput is 1 result per cycle.
- Elastic stall:
  - Stage k advances when stage k+1 is empty or advancing.
  - S3 advances when !out_valid || out_ready.
  - in_ready = !S1.valid || S1 advancing. It is combinational from out_ready through the stall chain; there are no other combinational input-to-output paths.
- While stalled, every stage holds its data unchanged. out_* stays stable while out_valid && !out_ready.
- Up to 3 results are held in flight. No result is dropped, duplicated or reordered.
- Arithmetic:
  - out_mant = in_mant << lz, truncated to W bits.
  - out_shift = lz.
  - If lz <= in_exp: out_exp = in_exp - lz and out_uf = 0.
  - If lz > in_exp: out_exp = 0 and out_uf = 1. out_mant is still fully normalized; denormal handling belongs to the rounder.
- Zero input: out_mant = 0, out_shift = W, out_exp = 0, out_zero = 1, out_uf = 0. Zero takes priority over underflow.
- Already normalized input (in_mant[W-1] = 1): out_mant = in_mant, out_shift = 0, out_exp = in_exp.
- Reset:
  - While rst is high on a clock edge, all stage valid bits clear to 0.
  - out_valid = 0, out_mant = 0, out_exp = 0, out_shift = 0, out_zero = 0, out_uf = 0.
  - in_ready = 1 in the first cycle after rst deasserts.
  - In-flight data is discarded. Reset mid-stall is legal and has the same effect.
- Simultaneous events: an input transfer and an output transfer in the same cycle with a full pipeline is legal and keeps full throughput.
- No state machine beyond the per-stage valid bits.

Test Plan:
- Basic shift: in_mant=48'h0000_0000_0001, in_exp=100 -> after 3 cycles out_mant=48'h8000_0000_0000, out_shift=47, out_exp=53, out_zero=0, out_uf=0.
- Normalized and zero back-to-back:
  - Input 48'h8000_0000_0000 with exp 5 -> shift 0, exp 5.
  - Next cycle, input 0 with exp 77 -> out_mant=0, out_shift=48, out_exp=0, out_zero=1.
  - Results appear on consecutive cycles.
- Underflow: in_mant=48'h0000_0001_0000 (lz=31), in_exp=10 -> out_mant=48'h8000_0000_0000, out_shift=31, out_exp=0, out_uf=1.
- Backpressure:
  - Stream 5 inputs (lz=0,1,2,3,4, exp=20) with out_ready=0 for 6 cycles.
  - in_ready falls after 3 accepted inputs and out_* stays stable.
  - Release out_ready -> all 5 results arrive in order (exp 20,19,18,17,16) with no gaps once flowing.
- Reset mid-operation: accept 2 inputs, assert rst for 1 cycle at cycle 2 -> out_valid never asserts for those inputs, in_ready=1 after reset, and a new input yields a correct result 3 cycles later.
- Random sweep: 10,000 random in_mant/in_exp with random out_ready -> every result matches a reference model computing lz, shift and exponent clamp.
